// File: rtl/wash_panel_input.sv
// rtl/wash_panel_input.sv - panel/sensor conditioner feeding the wash controller bus_in
// Optional feature macro: WASH_LID_LOCK_EN (lid lock solenoid and safety abort on lid opening mid-cycle)
module wash_panel_input #(
   parameter int SYNC_STAGES     = 2,
   parameter int DEBOUNCE_CYCLES = 16,
   parameter int TICK_DIV        = 1000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       btn_start_raw,
   input  logic       btn_cancel_raw,
   input  logic       btn_temp_raw,
   input  logic       lid_closed_raw,
   input  logic       lvl_full_raw,
   input  logic       lvl_empty_raw,
   input  logic       busy,
   output logic [8:0] panel_bus,
   output logic       lid_lock
);

   // input vector order: 0 start, 1 cancel, 2 temp, 3 lid, 4 full, 5 empty
   localparam int NIN = 6;
   localparam int DW  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam int TW  = $clog2(TICK_DIV);
   localparam logic [DW-1:0] DEB_MAX  = DW'(DEBOUNCE_CYCLES - 1);
   localparam logic [TW-1:0] TICK_MAX = TW'(TICK_DIV - 1);

   logic [NIN-1:0] raw_vec;
   logic [NIN-1:0] sync_q [SYNC_STAGES];
   logic [NIN-1:0] synced;
   logic [NIN-1:0] deb_lvl;
   logic [DW-1:0]  deb_cnt [NIN];
   logic [2:0]     btn_d;
   logic [2:0]     btn_rise;
   logic           force_cancel;
   logic           cancel_req;
   logic           start_req;
   logic           start_p;
   logic           cancel_p;
   logic [2:0]     temp_sel;
   logic [TW-1:0]  tick_cnt;
   logic [TW-1:0]  tick_cnt_next;
   logic           tick_q;

   assign raw_vec = {lvl_empty_raw, lvl_full_raw, lid_closed_raw,
                     btn_temp_raw, btn_cancel_raw, btn_start_raw};
   assign synced  = sync_q[SYNC_STAGES-1];

   // synchroniser chain for every raw input
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
      end else begin
         sync_q[0] <= raw_vec;
         for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
      end
   end

   // per-input debounce: level follows only after DEBOUNCE_CYCLES consecutive differing cycles
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         deb_lvl <= '0;
         for (int i = 0; i < NIN; i++) deb_cnt[i] <= '0;
      end else begin
         for (int i = 0; i < NIN; i++) begin
            if (synced[i] == deb_lvl[i]) begin
               deb_cnt[i] <= '0;
            end else if (deb_cnt[i] == DEB_MAX) begin
               deb_lvl[i] <= synced[i];
               deb_cnt[i] <= '0;
            end else begin
               deb_cnt[i] <= deb_cnt[i] + DW'(1);
            end
         end
      end
   end

`ifdef WASH_LID_LOCK_EN
   logic lid_d;
   logic lid_lock_q;

   // lock follows busy one cycle late; remember lid level to spot it opening mid-cycle
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lid_d      <= 1'b0;
         lid_lock_q <= 1'b0;
      end else begin
         lid_d      <= deb_lvl[3];
         lid_lock_q <= busy;
      end
   end

   assign force_cancel = lid_d & ~deb_lvl[3] & busy;
   assign lid_lock     = lid_lock_q;
`else
   assign force_cancel = 1'b0;
   assign lid_lock     = 1'b0;
`endif

   // cancel wins over start; start also needs an idle controller and a closed lid
   assign btn_rise   = deb_lvl[2:0] & ~btn_d;
   assign cancel_req = btn_rise[1] | force_cancel;
   assign start_req  = btn_rise[0] & ~cancel_req & ~busy & deb_lvl[3];

   // tick counter wraps at TICK_DIV-1 and restarts from 0 after any cancel pulse
   always_comb begin
      tick_cnt_next = tick_cnt + TW'(1);
      if (cancel_p || (tick_cnt == TICK_MAX)) tick_cnt_next = '0;
   end

   // registered pulses, temperature rotation and tick output
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         btn_d    <= '0;
         start_p  <= 1'b0;
         cancel_p <= 1'b0;
         temp_sel <= 3'b001;
         tick_cnt <= '0;
         tick_q   <= 1'b0;
      end else begin
         btn_d    <= deb_lvl[2:0];
         start_p  <= start_req;
         cancel_p <= cancel_req;
         if (btn_rise[2] && !busy) temp_sel <= {temp_sel[1:0], temp_sel[2]};
         tick_cnt <= tick_cnt_next;
         tick_q   <= (tick_cnt_next == TICK_MAX) && !cancel_req;
      end
   end

   assign panel_bus = {deb_lvl[5], deb_lvl[4], tick_q, temp_sel, deb_lvl[3], cancel_p, start_p};

endmodule

// File: tb/tb_wash_panel_input.sv
// tb/tb_wash_panel_input.sv - scoreboard bench for wash_panel_input (macro WASH_LID_LOCK_EN aware)
module tb_wash_panel_input;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       btn_start_raw = 1'b0;
   logic       btn_cancel_raw = 1'b0;
   logic       btn_temp_raw = 1'b0;
   logic       lid_closed_raw = 1'b0;
   logic       lvl_full_raw = 1'b0;
   logic       lvl_empty_raw = 1'b0;
   logic       busy = 1'b0;
   logic [8:0] panel_bus;
   logic       lid_lock;

   wash_panel_input #(.SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .TICK_DIV(10)) dut (
      .clk(clk), .rst_n(rst_n),
      .btn_start_raw(btn_start_raw), .btn_cancel_raw(btn_cancel_raw),
      .btn_temp_raw(btn_temp_raw), .lid_closed_raw(lid_closed_raw),
      .lvl_full_raw(lvl_full_raw), .lvl_empty_raw(lvl_empty_raw),
      .busy(busy), .panel_bus(panel_bus), .lid_lock(lid_lock)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct { int cyc; logic [2:0] val; } ev_t;
   typedef struct { int cyc; logic [9:0] mask; logic [9:0] val; string name; } samp_t;

   ev_t   ev_q[$];
   samp_t samp_q[$];
   int    checks = 0;
   int    errors = 0;
   int    tick_lo = -1;
   int    tick_hi = -2;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cyc);
      end
   endtask

   task automatic step(input int k);
      repeat (k) @(negedge clk);
   endtask

   task automatic push_ev(input int c, input logic [2:0] v);
      ev_q.push_back('{cyc: c, val: v});
   endtask

   task automatic push_s(input int c, input logic [9:0] m, input logic [9:0] v, input string nm);
      samp_q.push_back('{cyc: c, mask: m, val: v, name: nm});
   endtask

   // monitor: pulses {tick(in window), cancel_p, start_p} and cycle-targeted bus samples
   always @(negedge clk) begin : mon
      logic [2:0] ev;
      ev_t        e;
      samp_t      s;
      ev = {(cyc >= tick_lo && cyc <= tick_hi) & panel_bus[6], panel_bus[1], panel_bus[0]};
      if (ev != 3'b000) begin
         if (ev_q.size() == 0) begin
            chk("unexpected_pulse", 32'(ev), 32'd0);
         end else begin
            e = ev_q.pop_front();
            chk("pulse_cycle", 32'(cyc), 32'(e.cyc));
            chk("pulse_kind", 32'(ev), 32'(e.val));
         end
      end else if (ev_q.size() > 0 && ev_q[0].cyc < cyc) begin
         e = ev_q.pop_front();
         chk("missed_pulse", 32'(ev), 32'(e.val));
      end
      while (samp_q.size() > 0 && samp_q[0].cyc <= cyc) begin
         s = samp_q.pop_front();
         chk(s.name, 32'({lid_lock, panel_bus} & s.mask), 32'(s.val));
      end
   end

   logic [9:0] temp_exp [4];
   logic [9:0] prev_temp;
   int n, c, m;

   initial begin
      temp_exp[0] = 10'h010;
      temp_exp[1] = 10'h020;
      temp_exp[2] = 10'h008;
      temp_exp[3] = 10'h010;

      // reset state
      step(3);
      chk("reset_bus", 32'({lid_lock, panel_bus}), 32'h008);
      rst_n = 1'b1;
      push_s(cyc + 1, 10'h3FF, 10'h008, "reset_state");
      step(2);

      // lid closes: debounced level appears SYNC+DEBOUNCE cycles later
      n = cyc;
      lid_closed_raw = 1'b1;
      push_s(n + 5, 10'h004, 10'h000, "lid_before");
      push_s(n + 6, 10'h004, 10'h004, "lid_after");
      step(10);

      // bouncy start, then held: one pulse 7 cycles after the last raw edge
      for (int i = 0; i < 20; i++) begin
         btn_start_raw = ((i % 4) < 2);
         step(1);
      end
      btn_start_raw = 1'b1;
      n = cyc;
      push_ev(n + 7, 3'b001);
      step(15);
      btn_start_raw = 1'b0;
      step(10);

      // temperature rotation
      prev_temp = 10'h008;
      for (int k = 0; k < 4; k++) begin
         n = cyc;
         btn_temp_raw = 1'b1;
         push_s(n + 6, 10'h038, prev_temp, "temp_hold");
         push_s(n + 7, 10'h038, temp_exp[k], "temp_step");
         step(9);
         btn_temp_raw = 1'b0;
         step(9);
         prev_temp = temp_exp[k];
      end

      // busy: temp press ignored, start suppressed, lock follows busy
      busy = 1'b1;
      step(1);
      n = cyc;
      btn_temp_raw = 1'b1;
      btn_start_raw = 1'b1;
      push_s(n + 8, 10'h038, 10'h010, "temp_busy");
`ifdef WASH_LID_LOCK_EN
      push_s(n + 8, 10'h200, 10'h200, "lid_lock_busy");
`else
      push_s(n + 8, 10'h200, 10'h000, "lid_lock_busy");
`endif
      step(10);
      btn_temp_raw = 1'b0;
      btn_start_raw = 1'b0;
      step(8);
      busy = 1'b0;
      step(3);

      // same-cycle start and cancel: cancel only
      n = cyc;
      btn_start_raw = 1'b1;
      btn_cancel_raw = 1'b1;
      push_ev(n + 7, 3'b010);
      step(10);
      btn_start_raw = 1'b0;
      btn_cancel_raw = 1'b0;
      step(10);

      // lid open: start gated
      lid_closed_raw = 1'b0;
      step(10);
      n = cyc;
      btn_start_raw = 1'b1;
      push_s(n + 8, 10'h004, 10'h000, "lid_open_gate");
      step(12);
      btn_start_raw = 1'b0;
      lid_closed_raw = 1'b1;
      step(10);

      // cancel realigns tick; then 10 ticks spaced exactly 10 cycles
      n = cyc;
      btn_cancel_raw = 1'b1;
      c = n + 7;
      push_ev(c, 3'b010);
      for (int k = 1; k <= 10; k++) push_ev(c + 10 * k, 3'b100);
      tick_lo = c + 1;
      tick_hi = c + 105;
      step(8);
      btn_cancel_raw = 1'b0;
      while (cyc < c + 106) step(1);
      tick_lo = -1;
      tick_hi = -2;

      // lid opens while busy
      busy = 1'b1;
      step(2);
      n = cyc;
      lid_closed_raw = 1'b0;
`ifdef WASH_LID_LOCK_EN
      push_ev(n + 7, 3'b010);
      push_s(n + 6, 10'h204, 10'h200, "lid_fall_locked");
      push_s(n + 12, 10'h200, 10'h200, "lid_lock_hold");
`else
      push_s(n + 6, 10'h204, 10'h000, "lid_fall_unlocked");
      push_s(n + 12, 10'h200, 10'h000, "lid_lock_tied");
`endif
      step(14);
      busy = 1'b0;
      m = cyc;
      push_s(m + 1, 10'h200, 10'h000, "lid_unlock");
      lid_closed_raw = 1'b1;
      step(10);

      // mid-run reset with buttons held
      n = cyc;
      btn_start_raw = 1'b1;
      btn_temp_raw = 1'b1;
      push_ev(n + 7, 3'b001);
      push_s(n + 8, 10'h03C, 10'h024, "pre_reset_bus");
      step(8);
      busy = 1'b1;
      step(2);
      rst_n = 1'b0;
      #1;
      chk("reset_midrun", 32'({lid_lock, panel_bus}), 32'h008);
      btn_start_raw = 1'b0;
      btn_temp_raw = 1'b0;
      busy = 1'b0;
      step(3);
      chk("reset_held", 32'({lid_lock, panel_bus}), 32'h008);
      rst_n = 1'b1;
      step(12);

      chk("ev_queue_empty", 32'(ev_q.size()), 32'd0);
      chk("samp_queue_empty", 32'(samp_q.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
